// File: rtl/bram_manager_mc.sv
// bram_manager_mc: multi-bank row-serial matrix store; define BRAM_MGR_RD_LAT2_EN to register the RAM output (read latency 2)
module bram_manager_mc #(
  parameter int D_W = 8,
  parameter int ROWS = 16,
  parameter int COLS = 128,
  parameter int NUM_BLK = 4,
  parameter int SEL_W = $clog2(NUM_BLK)
) (
  input  logic                                  I_CLK,
  input  logic                                  I_RST_N,
  input  logic                                  I_RD_ENA,
  input  logic                                  I_WR_ENA,
  input  logic [SEL_W-1:0]                      I_SEL,
  input  logic [0:ROWS-1][0:COLS-1][D_W-1:0]    I_MAT,
  output logic [0:ROWS-1][0:COLS-1][D_W-1:0]    O_MAT,
  output logic                                  O_VLD,
  output logic                                  O_WR_DONE,
  output logic                                  O_BUSY,
  output logic                                  O_ERR
);
`ifdef BRAM_MGR_RD_LAT2_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(NUM_BLK * ROWS);
  localparam int WW = COLS * D_W;
  typedef enum logic [2:0] {IDLE, RD, RD_DRAIN, WR, DONE} state_t;
  state_t                               state_q, state_d;
  logic [RW-1:0]                        row_q, row_d;
  logic [SEL_W-1:0]                     sel_q, sel_d;
  logic                                 wr_q, wr_d;
  logic [1:0]                           drain_q, drain_d;
  logic                                 err_d;
  logic                                 last_row;
  logic [AW-1:0]                        addr;
  logic [WW-1:0]                        mem [NUM_BLK*ROWS];
  logic [WW-1:0]                        ram_q;
  logic [WW-1:0]                        rdata;
  logic [RD_LAT-1:0]                    pv_q;
  logic [RD_LAT-1:0][RW-1:0]            prow_q;
  logic [0:ROWS-1][0:COLS-1][D_W-1:0]   mat_q;
  logic                                 vld_q, wr_done_q, busy_q, err_q;
  assign last_row  = row_q == RW'(ROWS - 1);
  assign addr      = AW'(sel_q) * AW'(ROWS) + AW'(row_q);
  assign O_MAT     = mat_q;
  assign O_VLD     = vld_q;
  assign O_WR_DONE = wr_done_q;
  assign O_BUSY    = busy_q;
  assign O_ERR     = err_q;
  // command acceptance, row sequencing and drain of the RAM read pipeline
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    drain_d = (state_q == RD_DRAIN) ? drain_q + 2'd1 : 2'd0;
    case (state_q)
      IDLE: if (I_RD_ENA || I_WR_ENA) begin
        if (32'(I_SEL) >= NUM_BLK) err_d = 1'b1;
        else begin
          state_d = I_WR_ENA ? WR : RD;
          wr_d    = I_WR_ENA;
          sel_d   = I_SEL;
          row_d   = '0;
          err_d   = I_RD_ENA && I_WR_ENA;
        end
      end
      RD: begin
        row_d   = last_row ? '0 : row_q + RW'(1);
        state_d = last_row ? RD_DRAIN : RD;
      end
      RD_DRAIN: state_d = (drain_q == 2'(RD_LAT - 1)) ? DONE : RD_DRAIN;
      WR: begin
        row_d   = last_row ? '0 : row_q + RW'(1);
        state_d = last_row ? DONE : WR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && (I_RD_ENA || I_WR_ENA)) err_d = 1'b1;
  end
  // control state, read-capture pipeline, result matrix and registered status outputs
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q   <= IDLE;
      row_q     <= '0;
      sel_q     <= '0;
      wr_q      <= 1'b0;
      drain_q   <= '0;
      pv_q      <= '0;
      prow_q    <= '0;
      mat_q     <= '0;
      vld_q     <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      drain_q   <= drain_d;
      pv_q[0]   <= state_q == RD;
      prow_q[0] <= row_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        prow_q[i] <= prow_q[i-1];
      end
      if (pv_q[RD_LAT-1]) mat_q[prow_q[RD_LAT-1]] <= rdata;
      vld_q     <= state_d == DONE && !wr_q;
      wr_done_q <= state_d == DONE && wr_q;
      busy_q    <= state_d != IDLE;
      err_q     <= err_d;
    end
  end
  // matrix RAM: one row word per address, synchronous read, contents never reset
  always_ff @(posedge I_CLK) begin
    if (state_q == WR) mem[addr] <= I_MAT[row_q];
    ram_q <= mem[addr];
  end
`ifdef BRAM_MGR_RD_LAT2_EN
  logic [WW-1:0] ram2_q;
  // extra RAM output register for the two-cycle read build
  always_ff @(posedge I_CLK) ram2_q <= ram_q;
  assign rdata = ram2_q;
`else
  assign rdata = ram_q;
`endif
endmodule

// File: tb/tb_bram_manager_mc.sv
// tb_bram_manager_mc: scoreboard bench for bram_manager_mc
module tb_bram_manager_mc;
  localparam int D_W = 8;
  localparam int ROWS = 16;
  localparam int COLS = 128;
  localparam int NUM_BLK = 4;
  localparam int SEL_W = 3;
`ifdef BRAM_MGR_RD_LAT2_EN
  localparam int VLD_OFF = ROWS + 3;
`else
  localparam int VLD_OFF = ROWS + 2;
`endif
  localparam int WD_OFF = ROWS + 1;
  typedef logic [0:ROWS-1][0:COLS-1][D_W-1:0] mat_t;
  typedef struct {int cyc; int pat;} ev_t;
  logic I_CLK = 1'b0;
  logic I_RST_N = 1'b0;
  logic I_RD_ENA = 1'b0;
  logic I_WR_ENA = 1'b0;
  logic [SEL_W-1:0] I_SEL = '0;
  mat_t I_MAT = '0;
  mat_t O_MAT;
  logic O_VLD, O_WR_DONE, O_BUSY, O_ERR;
  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  int bank_pat [NUM_BLK];
  ev_t vq[$];
  ev_t wq[$];
  ev_t eq[$];
  ev_t mon_e;

  bram_manager_mc #(.D_W(D_W), .ROWS(ROWS), .COLS(COLS), .NUM_BLK(NUM_BLK), .SEL_W(SEL_W)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_RD_ENA(I_RD_ENA), .I_WR_ENA(I_WR_ENA),
    .I_SEL(I_SEL), .I_MAT(I_MAT), .O_MAT(O_MAT), .O_VLD(O_VLD),
    .O_WR_DONE(O_WR_DONE), .O_BUSY(O_BUSY), .O_ERR(O_ERR)
  );

  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic mat_t mk(int p);
    mat_t m;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[r][c] = (p < 0) ? 8'((r * 8 + c) & 255) : 8'(p);
    return m;
  endfunction

  task automatic chk(string n, int got, int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  task automatic chk_mat(string n, mat_t got, mat_t exp);
    bit shown;
    vecs++;
    shown = 1'b0;
    if (got !== exp) begin
      errs++;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (!shown && got[r][c] !== exp[r][c]) begin
            shown = 1'b1;
            $display("FAIL %s: element [%0d][%0d] got 0x%02h expected 0x%02h", n, r, c, got[r][c], exp[r][c]);
          end
    end
  endtask

  // issue one command for a single cycle and push what the DUT must answer with
  task automatic issue(bit rd, bit wr, int sel, int pat, bit ev_vld, bit ev_wd, bit ev_err, bit exp_busy);
    int c;
    @(negedge I_CLK);
    I_RD_ENA = rd;
    I_WR_ENA = wr;
    I_SEL = SEL_W'(sel);
    if (ev_wd) I_MAT = mk(pat);
    c = cyc;
    if (ev_vld) vq.push_back('{c + VLD_OFF, bank_pat[sel]});
    if (ev_wd) begin
      wq.push_back('{c + WD_OFF, pat});
      bank_pat[sel] = pat;
    end
    if (ev_err) eq.push_back('{c + 1, 0});
    @(negedge I_CLK);
    I_RD_ENA = 1'b0;
    I_WR_ENA = 1'b0;
    chk("busy_after_cmd", int'(O_BUSY), int'(exp_busy));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (O_BUSY && n < 40) begin
      @(negedge I_CLK);
      n++;
    end
    chk("idle_within_budget", int'(n < 40), 1);
  endtask

  // monitor: pops expected events whenever the DUT raises a status pulse
  always @(negedge I_CLK) if (I_RST_N) begin
    if (O_VLD) begin
      chk("vld_expected", int'(vq.size() != 0), 1);
      if (vq.size() != 0) begin
        mon_e = vq.pop_front();
        chk("vld_cycle", cyc, mon_e.cyc);
        chk_mat("vld_data", O_MAT, mk(mon_e.pat));
      end
    end
    if (O_WR_DONE) begin
      chk("wr_done_expected", int'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        mon_e = wq.pop_front();
        chk("wr_done_cycle", cyc, mon_e.cyc);
      end
    end
    if (O_ERR) begin
      chk("err_expected", int'(eq.size() != 0), 1);
      if (eq.size() != 0) begin
        mon_e = eq.pop_front();
        chk("err_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    for (int b = 0; b < NUM_BLK; b++) bank_pat[b] = 0;
    repeat (3) @(negedge I_CLK);
    chk("rst_vld", int'(O_VLD), 0);
    chk("rst_wr_done", int'(O_WR_DONE), 0);
    chk("rst_busy", int'(O_BUSY), 0);
    chk("rst_err", int'(O_ERR), 0);
    chk_mat("rst_mat", O_MAT, mk(0));
    I_RST_N = 1'b1;
    repeat (2) @(negedge I_CLK);
    // ramp pattern round trip through bank 1
    issue(0, 1, 1, -1, 0, 1, 0, 1);
    wait_idle();
    issue(1, 0, 1, 0, 1, 0, 0, 1);
    wait_idle();
    // bank isolation with distinct constants
    for (int b = 0; b < NUM_BLK; b++) begin
      issue(0, 1, b, 16 * (b + 1), 0, 1, 0, 1);
      wait_idle();
    end
    issue(1, 0, 3, 0, 1, 0, 0, 1);
    wait_idle();
    issue(1, 0, 0, 0, 1, 0, 0, 1);
    wait_idle();
    issue(1, 0, 2, 0, 1, 0, 0, 1);
    wait_idle();
    issue(1, 0, 1, 0, 1, 0, 0, 1);
    wait_idle();
    // read and write together: the write wins and the read is flagged
    issue(1, 1, 2, 8'h55, 0, 1, 1, 1);
    wait_idle();
    issue(1, 0, 2, 0, 1, 0, 0, 1);
    wait_idle();
    // out-of-range bank select is rejected without going busy
    issue(1, 0, 4, 0, 0, 0, 1, 0);
    issue(0, 1, 5, 8'h99, 0, 0, 1, 0);
    issue(1, 1, 7, 8'h99, 0, 0, 1, 0);
    // commands during a read are rejected and the read completes intact
    issue(1, 0, 3, 0, 1, 0, 0, 1);
    repeat (3) @(negedge I_CLK);
    issue(1, 0, 0, 0, 0, 0, 1, 1);
    issue(0, 1, 1, 0, 0, 0, 1, 1);
    wait_idle();
    // asynchronous reset in the middle of a read
    issue(1, 0, 1, 0, 0, 0, 0, 1);
    repeat (6) @(negedge I_CLK);
    chk("busy_before_reset", int'(O_BUSY), 1);
    I_RST_N = 1'b0;
    #1;
    chk("arst_vld", int'(O_VLD), 0);
    chk("arst_wr_done", int'(O_WR_DONE), 0);
    chk("arst_busy", int'(O_BUSY), 0);
    chk("arst_err", int'(O_ERR), 0);
    chk_mat("arst_mat", O_MAT, mk(0));
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    @(negedge I_CLK);
    issue(1, 0, 1, 0, 1, 0, 0, 1);
    wait_idle();
    issue(1, 0, 2, 0, 1, 0, 0, 1);
    wait_idle();
    repeat (5) @(negedge I_CLK);
    chk("vld_left", vq.size(), 0);
    chk("wr_done_left", wq.size(), 0);
    chk("err_left", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
